// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 request demultiplexer and its
// outstanding-response tracker.
package demux_pkg;

    localparam int NUM_PORTS = 4;

    typedef logic [1:0] port_sel_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    function automatic logic [NUM_PORTS-1:0] sel_mask(input port_sel_t s);
        return {{(NUM_PORTS-1){1'b0}}, 1'b1} << s;
    endfunction

endpackage

// File: rtl/sel_fifo.sv
// FIFO of destination port indices, one entry per request that has
// left the demux and still owes a response.
module sel_fifo
    import demux_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  port_sel_t push_sel,
    input  logic      pop,
    output port_sel_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    port_sel_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when a pop frees a slot.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_sel;
    end

endmodule

// File: rtl/req_demux4.sv
// Routes one upstream request stream to four downstream ports and
// returns their responses upstream in issue order.
module req_demux4
    import demux_pkg::*;
#(
    parameter int OST_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  port_sel_t                   req_sel,
    input  logic [31:0]                 req_addr,
    input  logic [31:0]                 req_wdata,
    input  logic                        req_we,
    output logic [NUM_PORTS-1:0]        dn_valid,
    input  logic [NUM_PORTS-1:0]        dn_ready,
    output logic [31:0]                 dn_addr,
    output logic [31:0]                 dn_wdata,
    output logic                        dn_we,
    input  logic [NUM_PORTS-1:0]        dn_rsp_valid,
    input  logic [NUM_PORTS-1:0][31:0]  dn_rsp_rdata,
    output logic                        rsp_valid,
    output logic [31:0]                 rsp_rdata,
    output logic                        err_order
);

    logic      out_valid;
    port_sel_t out_sel;
    req_t      out_req;
    logic      drain;
    logic      accept;

    port_sel_t                 head;
    logic                      ost_full;
    logic                      ost_empty;
    logic                      hit;
    logic                      stray;
    logic [NUM_PORTS-1:0]      head_mask;

    assign drain     = out_valid && dn_ready[out_sel];
    assign req_ready = (!out_valid || drain) && !ost_full;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sel   <= '0;
            out_req   <= '0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_sel       <= req_sel;
            out_req.addr  <= req_addr;
            out_req.wdata <= req_wdata;
            out_req.we    <= req_we;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    assign dn_valid = out_valid ? sel_mask(out_sel) : '0;
    assign dn_addr  = out_req.addr;
    assign dn_wdata = out_req.wdata;
    assign dn_we    = out_req.we;

    sel_fifo #(
        .DEPTH    (OST_DEPTH)
    ) u_ost (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (drain),
        .push_sel (out_sel),
        .pop      (hit),
        .head     (head),
        .full     (ost_full),
        .empty    (ost_empty)
    );

    // Only the head port may answer; anything else is an ordering fault.
    assign head_mask = sel_mask(head);
    assign hit       = !ost_empty && dn_rsp_valid[head];
    assign stray     = ost_empty ? |dn_rsp_valid
                                 : |(dn_rsp_valid & ~head_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            err_order <= 1'b0;
        end else begin
            rsp_valid <= hit;
            if (hit) rsp_rdata <= dn_rsp_rdata[head];
            err_order <= err_order | stray;
        end
    end

endmodule

// File: tb/tb_req_demux4.sv
// Directed bench for req_demux4: latency, streaming, backpressure,
// response ordering, stray responses and asynchronous reset.
module tb_req_demux4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_sel;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              req_we;
    logic [3:0]        dn_valid;
    logic [3:0]        dn_ready;
    logic [31:0]       dn_addr;
    logic [31:0]       dn_wdata;
    logic              dn_we;
    logic [3:0]        dn_rsp_valid;
    logic [3:0][31:0]  dn_rsp_rdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              err_order;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    req_demux4 #(.OST_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sel      (req_sel),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_we       (req_we),
        .dn_valid     (dn_valid),
        .dn_ready     (dn_ready),
        .dn_addr      (dn_addr),
        .dn_wdata     (dn_wdata),
        .dn_we        (dn_we),
        .dn_rsp_valid (dn_rsp_valid),
        .dn_rsp_rdata (dn_rsp_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .err_order    (err_order)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [1:0] s,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic w);
        req_valid = v;
        req_sel   = s;
        req_addr  = a;
        req_wdata = d;
        req_we    = w;
    endtask

    task automatic respond(input int p, input logic [31:0] d);
        dn_rsp_valid    = 4'b0001 << p;
        dn_rsp_rdata[p] = d;
    endtask

    // One read to port 2, response three cycles after acceptance.
    task automatic single_read(input string pfx);
        drive_req(1'b1, 2'd2, 32'h100, 32'h0, 1'b0);
        #1 chk({pfx, "_ready"}, 32'(req_ready), 32'd1);
        tick();
        drive_req(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        #1 chk({pfx, "_dn_valid"}, 32'(dn_valid), 32'h4);
        chk({pfx, "_dn_addr"}, dn_addr, 32'h100);
        chk({pfx, "_dn_we"}, 32'(dn_we), 32'd0);
        tick();
        #1 chk({pfx, "_dn_idle"}, 32'(dn_valid), 32'h0);
        tick();
        respond(2, 32'hDEADBEEF);
        #1 chk({pfx, "_rsp_early"}, 32'(rsp_valid), 32'd0);
        tick();
        dn_rsp_valid = 4'b0;
        #1 chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({pfx, "_rsp_rdata"}, rsp_rdata, 32'hDEADBEEF);
        tick();
        #1 chk({pfx, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
        chk({pfx, "_rsp_hold"}, rsp_rdata, 32'hDEADBEEF);
    endtask

    logic [1:0]  seq [4];
    logic [31:0] dat [4];

    initial begin
        rst_n        = 1'b0;
        dn_ready     = 4'b1111;
        dn_rsp_valid = 4'b0;
        dn_rsp_rdata = '0;
        drive_req(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        #2;
        chk("rst_dn_valid", 32'(dn_valid), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(err_order), 32'd0);
        chk("rst_dn_addr", dn_addr, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        single_read("rd");

        // Streaming to ports 0..3 fills the tracker to its depth.
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 2'(i), 32'h10 + 32'(i), 32'h0, 1'b0);
            #1 chk("b2b_ready", 32'(req_ready), 32'd1);
            if (i > 0) begin
                chk("b2b_dn_valid", 32'(dn_valid), 32'(4'b0001 << (i - 1)));
                chk("b2b_dn_addr", dn_addr, 32'h10 + 32'(i - 1));
            end
            tick();
        end
        drive_req(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        #1 chk("b2b_last_valid", 32'(dn_valid), 32'h8);
        chk("b2b_last_addr", dn_addr, 32'h13);
        chk("b2b_ready3", 32'(req_ready), 32'd1);
        tick();
        #1 chk("b2b_full_ready", 32'(req_ready), 32'd0);
        chk("b2b_full_idle", 32'(dn_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            respond(i, 32'hA0 + 32'(i));
            tick();
            dn_rsp_valid = 4'b0;
            #1 chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("b2b_rsp_rdata", rsp_rdata, 32'hA0 + 32'(i));
            chk("b2b_ready_free", 32'(req_ready), 32'd1);
        end
        chk("b2b_err", 32'(err_order), 32'd0);

        // Port 1 stalls for three cycles with a second request waiting.
        dn_ready = 4'b1101;
        drive_req(1'b1, 2'd1, 32'h200, 32'h55, 1'b1);
        tick();
        drive_req(1'b1, 2'd0, 32'h300, 32'h66, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_dn_valid", 32'(dn_valid), 32'h2);
            chk("bp_dn_addr", dn_addr, 32'h200);
            chk("bp_dn_wdata", dn_wdata, 32'h55);
            chk("bp_dn_we", 32'(dn_we), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        dn_ready = 4'b1111;
        #1 chk("bp_release_ready", 32'(req_ready), 32'd1);
        tick();
        drive_req(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        #1 chk("bp_next_valid", 32'(dn_valid), 32'h1);
        chk("bp_next_addr", dn_addr, 32'h300);
        chk("bp_next_we", 32'(dn_we), 32'd0);
        tick();
        respond(1, 32'h11111111);
        tick();
        respond(0, 32'h22222222);
        #1 chk("bp_rsp1", rsp_rdata, 32'h11111111);
        tick();
        dn_rsp_valid = 4'b0;
        #1 chk("bp_rsp0", rsp_rdata, 32'h22222222);
        chk("bp_rsp0_valid", 32'(rsp_valid), 32'd1);

        // Out-of-order ports 3,0,3,1 must return strictly in issue order.
        seq[0] = 2'd3; seq[1] = 2'd0; seq[2] = 2'd3; seq[3] = 2'd1;
        dat[0] = 32'hC0DE0003; dat[1] = 32'hC0DE0000;
        dat[2] = 32'hC0DE1003; dat[3] = 32'hC0DE0001;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, seq[i], 32'h40 + 32'(i), 32'h0, 1'b0);
            tick();
        end
        drive_req(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            respond(int'(seq[i]), dat[i]);
            tick();
            dn_rsp_valid = 4'b0;
            #1 chk("ord_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("ord_rsp_rdata", rsp_rdata, dat[i]);
        end
        chk("ord_err", 32'(err_order), 32'd0);

        // A response from a non-head port is flagged and not routed.
        drive_req(1'b1, 2'd3, 32'h500, 32'h0, 1'b0);
        tick();
        drive_req(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        tick();
        respond(1, 32'hBAD00001);
        tick();
        dn_rsp_valid = 4'b0;
        #1 chk("err_set", 32'(err_order), 32'd1);
        chk("err_no_rsp", 32'(rsp_valid), 32'd0);
        respond(3, 32'h600D0003);
        tick();
        dn_rsp_valid = 4'b0;
        #1 chk("err_head_valid", 32'(rsp_valid), 32'd1);
        chk("err_head_rdata", rsp_rdata, 32'h600D0003);
        chk("err_sticky", 32'(err_order), 32'd1);

        // Reset with two outstanding and one request stuck on port 2.
        drive_req(1'b1, 2'd0, 32'h700, 32'h0, 1'b0);
        tick();
        drive_req(1'b1, 2'd1, 32'h701, 32'h0, 1'b0);
        tick();
        dn_ready = 4'b1011;
        drive_req(1'b1, 2'd2, 32'h702, 32'h77, 1'b1);
        tick();
        drive_req(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        #1 chk("pre_rst_valid", 32'(dn_valid), 32'h4);
        rst_n = 1'b0;
        #1 chk("arst_dn_valid", 32'(dn_valid), 32'h0);
        chk("arst_dn_addr", dn_addr, 32'h0);
        chk("arst_dn_wdata", dn_wdata, 32'h0);
        chk("arst_dn_we", 32'(dn_we), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_rdata", rsp_rdata, 32'h0);
        chk("arst_err", 32'(err_order), 32'd0);
        tick();
        dn_ready = 4'b1111;
        rst_n = 1'b1;

        single_read("post");
        chk("post_err", 32'(err_order), 32'd0);

        // Nothing outstanding now, so any response is stray.
        respond(0, 32'h0BADBAD0);
        tick();
        dn_rsp_valid = 4'b0;
        #1 chk("late_rsp_err", 32'(err_order), 32'd1);
        chk("late_rsp_none", 32'(rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/req_demux4.md
REQ_DEMUX4 -- requirements
Module: req_demux4

Interface
REQ-001 Parameter: OST_DEPTH, 4, outstanding-request tracking depth; SHALL be a power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 Port: rst_n  input  1  reset; SHALL be asynchronous, active-low.
REQ-004 Port: req_valid  input  1  upstream request valid.
REQ-005 Port: req_ready  output  1  upstream request accepted when req_valid && req_ready.
REQ-006 Port: req_sel  input  2  destination port index 0..3.
REQ-007 Port: req_addr  input  32  request address.
REQ-008 Port: req_wdata  input  32  write data.
REQ-009 Port: req_we  input  1  1 = write, 0 = read.
REQ-010 Port: dn_valid  output  4  per-port request valid, one-hot or zero.
REQ-011 Port: dn_ready  input  4  per-port ready.
REQ-012 Port: dn_addr / dn_wdata / dn_we  output  32/32/1  registered request fields, shared by all four ports.
REQ-013 Port: dn_rsp_valid  input  4  per-port response pulse.
REQ-014 Port: dn_rsp_rdata  input  4x32  per-port response data.
REQ-015 Port: rsp_valid  output  1  upstream response pulse; no backpressure.
REQ-016 Port: rsp_rdata  output  32  upstream response data.
REQ-017 Port: err_order  output  1  sticky flag for a response from a non-head port.

Function
REQ-018 Request path SHALL be a single output register holding valid, sel, addr, wdata, we.
REQ-019 dn_valid[i] SHALL equal out_valid && (out_sel == i).
REQ-020 Output register SHALL drain when dn_ready[out_sel] is high while out_valid is high.
REQ-021 req_ready SHALL equal (!out_valid || drain) && (ost_count < OST_DEPTH), with no combinational dependence on req_valid.
REQ-022 An accepted request SHALL appear on dn_* in the next cycle (latency 1).
REQ-023 Accept and drain in the same cycle SHALL load the new request with no bubble.
REQ-024 When a request drains, its sel SHALL be pushed into the outstanding FIFO in that cycle. Reads and writes both expect exactly one response.
REQ-025 Response routing: head = FIFO front. When dn_rsp_valid[head] is high and count > 0, then in the next cycle rsp_valid SHALL be 1 and rsp_rdata SHALL equal dn_rsp_rdata[head], and the FIFO SHALL pop.
REQ-026 Simultaneous push and pop SHALL leave count unchanged. Push while full SHALL be impossible by REQ-021.
REQ-027 Any dn_rsp_valid bit other than head, or any bit while count == 0, SHALL be ignored for routing and SHALL set err_order (sticky until reset).
REQ-028 rsp_valid SHALL be a single-cycle pulse per popped response. rsp_rdata SHALL hold its value when rsp_valid is low.
REQ-029 FIFO read and write pointers SHALL wrap modulo OST_DEPTH. count SHALL range 0..OST_DEPTH.
REQ-030 Fields on dn_* SHALL remain stable while dn_valid is high and not drained.

Reset
REQ-031 Asserting rst_n low SHALL immediately clear out_valid, ost_count, the FIFO pointers, rsp_valid and err_order. dn_addr, dn_wdata, dn_we and rsp_rdata SHALL reset to 0.
REQ-032 Reset mid-transaction SHALL discard in-flight requests and outstanding entries. Responses arriving after reset SHALL set err_order.
REQ-033 The first request SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-034 Package demux_pkg SHALL hold NUM_PORTS = 4, typedef port_sel_t (logic [1:0]), and typedef req_t (addr, wdata, we).
REQ-035 The outstanding FIFO SHALL be a sub-module sel_fifo, parameterized by depth and storing port_sel_t.
REQ-036 The routing mux SHALL index dn_rsp_rdata by port_sel_t, with no priority chain.

Verification
REQ-037 Single read: req sel=2, addr 0x100 accepted at cycle 0 -> dn_valid=4'b0100 at cycle 1; dn_rsp_valid[2] with 0xDEADBEEF at cycle 3 -> rsp_valid=1, rsp_rdata=0xDEADBEEF at cycle 4.
REQ-038 Back-to-back: sel 0,1,2,3 on consecutive cycles with all dn_ready=1 -> one request per cycle on dn_*, req_ready stays 1 until count reaches 4, then 0.
REQ-039 Backpressure: dn_ready[1]=0 for 3 cycles with sel=1 pending -> dn_* fields stable, req_ready=0; drains on the cycle ready rises.
REQ-040 Ordering: 4 outstanding to ports 3,0,3,1; responses return in that order with distinct data -> rsp_rdata matches in order; count returns to 0.
REQ-041 Error: dn_rsp_valid[1] while head=3 -> err_order=1, no rsp_valid; correct head response still routes.
REQ-042 Reset: drop rst_n with 2 outstanding and out_valid=1 -> all outputs 0 immediately; the next request after release behaves as in REQ-037.
